pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
- Program-counter and next-PC control block for the single-cycle core. It is the consumer of the ALU's result and Zero flag.
- Holds the architectural PC and handshakes fetches with instruction memory.
- Resolves BEQ/BNE/JAL/JALR using the ALU outputs and the immediate. Halts with a trap on a misaligned taken target.
- Also keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath / PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single core clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request for the instruction at pc.
- imem_ready  input  1  instruction memory has returned the instruction for pc this cycle.
- stall  input  1  hold the PC this cycle (hazard/external stall); the instruction does not retire.
- br_type  input  3  control-flow type of the current instruction, pc_pkg::br_type_e: BR_NONE=0, BR_BEQ=1, BR_BNE=2, BR_JAL=3, BR_JALR=4; values 5-7 are treated as BR_NONE.
- imm  input  XLEN  sign-extended immediate from the decoder; byte offset.
- alu_result  input  XLEN  ALU output; the JALR target before LSB clear.
- zero  input  1  ALU Zero flag, i.e. data1 == data2 for the branch compare.
- pc  output  XLEN  current PC.
- pc_plus4  output  XLEN  pc + 4, combinational; link value for JAL/JALR.
- taken  output  1  combinational; current instruction redirects the PC.
- trap  output  1  registered; misaligned-target trap, core halted.
- trap_pc  output  XLEN  registered; PC of the faulting instruction.
- instret  output  32  registered count of retired instructions.

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high, port reset. Nothing is sampled asynchronously.
- Reset values:
  - pc = RESET_PC, instret = 0, trap = 0, trap_pc = 0.
  - state = S_FETCH; imem_req = 1 in the first cycle after reset is released.
- Reset mid-operation: reset wins over every other input in the same cycle, from any state, including S_HALT.
- FSM states: S_FETCH, S_HALT.
  - S_FETCH: imem_req = 1.
  - S_HALT: imem_req = 0, taken = 0; pc, instret and trap_pc are frozen and trap = 1. S_HALT is left only via reset.
- Retire condition: retire = state==S_FETCH && imem_ready && !stall.
- imem_ready with stall=1: no retire, PC held, imem_req stays high.
- Target and taken, all arithmetic modulo 2^XLEN:
  - BEQ: taken = zero; target = pc + imm.
  - BNE: taken = !zero; target = pc + imm.
  - JAL: taken = 1; target = pc + imm.
  - JALR: taken = 1; target = alu_result & ~1.
  - BR_NONE: taken = 0; next = pc + 4.
  - taken is forced to 0 whenever state != S_FETCH.
- Next PC: next = taken ? target : pc + 4. PC wrap from 32'hFFFF_FFFC to 0 is legal and not a trap.
- Misalignment: misalign = taken && target[1:0] != 0.
- On retire && !misalign:
  - pc <= next; instret <= instret + 1.
  - instret wraps 32'hFFFF_FFFF -> 0.
- On retire && misalign:
  - pc holds; instret not incremented, because the faulting instruction does not retire.
  - trap <= 1; trap_pc <= pc; state <= S_HALT.
- Misalignment is evaluated only on retire cycles; a misaligned target while stall=1 or imem_ready=0 has no effect.
- Latency: PC redirect takes effect on the edge of the retire cycle. There is no delay slot and no bubble.

Decomposition:
- pc_pkg holds:
  - typedef enum logic [2:0] br_type_e;
  - typedef enum logic state_e {S_FETCH, S_HALT};
  - localparam PC_STEP = 4.
- One natural sub-module: pc_target, a combinational block with inputs br_type, pc, imm, alu_result, zero and outputs taken, target, misalign. The FSM and registers remain in pc_ctrl.

Test Plan:
1. Reset and sequential fetch: reset 2 cycles, then imem_ready=1, BR_NONE for 3 cycles -> pc = 0, 4, 8, 12; instret = 3; imem_req = 1 throughout.
2. BEQ both ways:
   - pc=0x10, imm=0xFFFF_FFF8 (-8), zero=1 -> taken=1, next pc=0x08.
   - Same inputs with zero=0 -> next pc=0x14.
   - BNE with zero=0, imm=0x20 -> next pc=0x30.
3. JAL/JALR:
   - JAL at pc=0x40, imm=0x100 -> pc_plus4=0x44, next pc=0x140.
   - JALR with alu_result=0x0000_0203 -> next pc=0x200 (LSB cleared, bit1=1 -> trap case; use 0x201 -> next pc=0x200).
4. Stall and memory wait: imem_ready=0 for 2 cycles, then ready with stall=1 for 1 cycle -> pc unchanged and instret unchanged across all 3 cycles; the next ready && !stall cycle advances pc by 4.
5. Misaligned trap: at pc=0x80, BEQ with zero=1 and imm=0x6 -> trap=1, trap_pc=0x80, pc stays 0x80, imem_req=0, instret unchanged. Further inputs are ignored; reset then returns pc=RESET_PC, trap=0.
6. Wrap and reset priority:
   - pc=0xFFFF_FFFC with BR_NONE -> pc=0, no trap.
   - instret preloaded near 0xFFFF_FFFF wraps to 0.
   - reset asserted in the same cycle as a taken JAL -> pc=RESET_PC, instret=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter control block.
// Branch encodings match the decoder's br_type field.
package pc_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_JAL  = 3'd3,
        BR_JALR = 3'd4
    } br_type_e;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_e;

    localparam int PC_STEP = 4;

endpackage : pc_pkg

// File: rtl/pc_target.sv
// Combinational branch/jump resolution: decides whether the current
// instruction redirects the PC, where to, and whether that target is misaligned.
module pc_target
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_br_type,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_zero,
    output logic            o_taken,
    output logic [XLEN-1:0] o_target,
    output logic            o_misalign
);

    localparam logic [XLEN-1:0] LSB_CLEAR = {{(XLEN-1){1'b1}}, 1'b0};

    logic            w_taken;
    logic [XLEN-1:0] w_target;

    // NOTE: every output of this always_comb gets a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_taken  = 1'b0;
        w_target = i_pc + i_imm;
        case (i_br_type)
            BR_BEQ:  w_taken = i_zero;
            BR_BNE:  w_taken = ~i_zero;
            BR_JAL:  w_taken = 1'b1;
            BR_JALR: begin
                w_taken  = 1'b1;
                w_target = i_alu_result & LSB_CLEAR;
            end
            default: w_taken = 1'b0;  // BR_NONE and the unused encodings 5..7
        endcase
    end

    assign o_taken    = w_taken;
    assign o_target   = w_target;
    assign o_misalign = w_taken && (w_target[1:0] != 2'b00);

endmodule : pc_target

// File: rtl/pc_ctrl.sv
// Program counter, fetch handshake, retired-instruction counter and
// misaligned-target trap for the single-cycle core.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            zero,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            taken,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     instret
);

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_trap_pc;
    logic [31:0]     r_instret;
    logic            r_trap;

    logic            w_taken_raw;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;
    logic            w_retire;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;

    pc_target #(.XLEN(XLEN)) u_pc_target (
        .i_br_type    (br_type),
        .i_pc         (r_pc),
        .i_imm        (imm),
        .i_alu_result (alu_result),
        .i_zero       (zero),
        .o_taken      (w_taken_raw),
        .o_target     (w_target),
        .o_misalign   (w_misalign)
    );

    assign w_pc_plus4 = r_pc + XLEN'(PC_STEP);

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        taken        = 1'b0;
        w_retire     = 1'b0;
        w_next_pc    = w_pc_plus4;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                taken    = w_taken_raw;
                w_retire = imem_ready && !stall;
                if (w_taken_raw) begin
                    w_next_pc = w_target;
                end
                if (w_retire && w_misalign) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT:  w_state_next = S_HALT;  // only reset leaves the halt
            default: w_state_next = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A faulting instruction does not retire: the PC and counter hold,
    // and the trap records the PC that produced the bad target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
        end else if (w_retire) begin
            if (w_misalign) begin
                r_trap    <= 1'b1;
                r_trap_pc <= r_pc;
            end else begin
                r_pc      <= w_next_pc;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign trap     = r_trap;
    assign trap_pc  = r_trap_pc;
    assign instret  = r_instret;

endmodule : pc_ctrl

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: every expected PC/counter value is hand-computed
// from the instruction sequence applied below.
module tb_pc_ctrl;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic [2:0]  br_type;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    pc_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .stall      (stall),
        .br_type    (br_type),
        .imm        (imm),
        .alu_result (alu_result),
        .zero       (zero),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .taken      (taken),
        .trap       (trap),
        .trap_pc    (trap_pc),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one instruction's inputs and let combinational outputs settle.
    task automatic drive(input logic [2:0] bt, input logic [31:0] im, input logic [31:0] alu,
                         input logic z, input logic rdy, input logic st);
        br_type    = bt;
        imm        = im;
        alu_result = alu;
        zero       = z;
        imem_ready = rdy;
        stall      = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".instret"}, instret, e_ir);
    endtask

    initial begin
        reset = 1'b1;
        drive(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_state("rst", 32'h0, 32'd0);
        check("rst.trap", {31'd0, trap}, 32'd0);
        check("rst.trap_pc", trap_pc, 32'h0);
        reset = 1'b0;
        #1;
        check("rst.imem_req", {31'd0, imem_req}, 32'd1);

        // 1. sequential fetch
        drive(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("seq.pc_plus4", pc_plus4, 32'h4);
        tick(); check_state("seq1", 32'h4, 32'd1);
        tick(); check_state("seq2", 32'h8, 32'd2);
        tick(); check_state("seq3", 32'hC, 32'd3);
        check("seq.imem_req", {31'd0, imem_req}, 32'd1);
        tick(); check_state("seq4", 32'h10, 32'd4);

        // 2. BEQ taken backwards, back to 0x10, BEQ not taken, BNE both ways
        drive(BR_BEQ, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1, 1'b0);
        check("beq_t.taken", {31'd0, taken}, 32'd1);
        tick(); check_state("beq_t", 32'h8, 32'd5);
        drive(BR_JAL, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(); check_state("jal_fwd", 32'h10, 32'd6);
        drive(BR_BEQ, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b1, 1'b0);
        check("beq_nt.taken", {31'd0, taken}, 32'd0);
        tick(); check_state("beq_nt", 32'h14, 32'd7);
        drive(BR_BNE, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0);
        check("bne_t.taken", {31'd0, taken}, 32'd1);
        tick(); check_state("bne_t", 32'h34, 32'd8);
        drive(BR_BNE, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0);
        tick(); check_state("bne_nt", 32'h38, 32'd9);

        // 3. JAL / JALR
        drive(BR_JAL, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(); check_state("jal_40", 32'h40, 32'd10);
        drive(BR_JAL, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("jal.pc_plus4", pc_plus4, 32'h44);
        check("jal.taken", {31'd0, taken}, 32'd1);
        tick(); check_state("jal", 32'h140, 32'd11);
        drive(BR_JALR, 32'h0, 32'h0000_0201, 1'b0, 1'b1, 1'b0);
        tick(); check_state("jalr", 32'h200, 32'd12);
        check("jalr.trap", {31'd0, trap}, 32'd0);
        drive(3'd5, 32'h100, 32'h0, 1'b1, 1'b1, 1'b0);
        check("bt5.taken", {31'd0, taken}, 32'd0);
        tick(); check_state("bt5", 32'h204, 32'd13);

        // 4. memory wait and stall, including a misaligned target under stall
        drive(BR_JAL, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); check_state("wait1", 32'h204, 32'd13);
        tick(); check_state("wait2", 32'h204, 32'd13);
        check("wait.imem_req", {31'd0, imem_req}, 32'd1);
        drive(BR_JAL, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1);
        tick(); check_state("stall", 32'h204, 32'd13);
        check("stall.trap", {31'd0, trap}, 32'd0);
        check("stall.imem_req", {31'd0, imem_req}, 32'd1);
        drive(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(); check_state("resume", 32'h208, 32'd14);

        // 5. misaligned trap at 0x80 (JALR with bit0 set lands aligned)
        drive(BR_JALR, 32'h0, 32'h0000_0081, 1'b0, 1'b1, 1'b0);
        tick(); check_state("to80", 32'h80, 32'd15);
        drive(BR_BEQ, 32'h6, 32'h0, 1'b1, 1'b1, 1'b0);
        tick(); check_state("trap", 32'h80, 32'd15);
        check("trap.trap", {31'd0, trap}, 32'd1);
        check("trap.trap_pc", trap_pc, 32'h80);
        check("trap.imem_req", {31'd0, imem_req}, 32'd0);
        drive(BR_JAL, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        check("halt.taken", {31'd0, taken}, 32'd0);
        tick(); tick(); check_state("halt", 32'h80, 32'd15);
        check("halt.trap", {31'd0, trap}, 32'd1);
        check("halt.trap_pc", trap_pc, 32'h80);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_state("unhalt", 32'h0, 32'd0);
        check("unhalt.trap", {31'd0, trap}, 32'd0);
        check("unhalt.trap_pc", trap_pc, 32'h0);
        check("unhalt.imem_req", {31'd0, imem_req}, 32'd1);

        // 6. PC wrap, JALR bit1 trap, instret wrap, reset priority
        drive(BR_JALR, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        tick(); check_state("top", 32'hFFFF_FFFC, 32'd1);
        drive(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("top.pc_plus4", pc_plus4, 32'h0);
        tick(); check_state("pcwrap", 32'h0, 32'd2);
        check("pcwrap.trap", {31'd0, trap}, 32'd0);
        drive(BR_JALR, 32'h0, 32'h0000_0203, 1'b0, 1'b1, 1'b0);
        tick(); check_state("jalr_mis", 32'h0, 32'd2);
        check("jalr_mis.trap", {31'd0, trap}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        force dut.r_instret = 32'hFFFF_FFFE;
        #1;
        release dut.r_instret;
        drive(BR_NONE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(); check_state("irwrap1", 32'h4, 32'hFFFF_FFFF);
        tick(); check_state("irwrap2", 32'h8, 32'h0);
        tick(); check_state("irwrap3", 32'hC, 32'h1);
        reset = 1'b1;
        drive(BR_JAL, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
        tick(); check_state("rst_prio", 32'h0, 32'd0);
        reset = 1'b0;
        tick(); check_state("post_rst", 32'h100, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_ctrl
